// File: rtl/uart_program_loader.sv
// UART-fed program loader: decodes an 8N1 byte stream carrying a framed session
// (sync, length, hi/lo byte pairs) and writes each word into program memory.
module uart_program_loader #(
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 4,
  parameter int unsigned DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int unsigned CLKS_PER_BIT      = 16,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  program_write,
  output logic [ADDR_WIDTH-1:0] program_address,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic                  loading,
  output logic                  load_done,
  output logic                  frame_error
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned REM_W   = 9;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LEN, L_HI, L_LO} ld_state_t;

  // ---------------- receiver ----------------
  logic             rx_meta, rx_sync;
  logic [1:0]       flush_q;
  logic             armed_q, armed_d;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid, byte_valid_d;
  logic             frame_error_d;

  // Line synchronizer plus a short flush so a line held low through reset is not taken as a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      flush_q <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      flush_q <= {flush_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      armed_q     <= 1'b0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      armed_q     <= armed_d;
      byte_valid  <= byte_valid_d;
      frame_error <= frame_error_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    armed_d       = armed_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    if (flush_q[1] && rx_sync) armed_d = 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (armed_q && !rx_sync) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
          end else begin
            // Bad stop bit: re-arm only after the line has returned high
            frame_error_d = 1'b1;
            armed_d       = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_t                    ld_state_q, ld_state_d;
  logic [REM_W-1:0]             rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
  logic [INSTRUCTION_WIDTH-1:0] op_q, op_d;
  logic                         finish_q, finish_d;
  logic                         write_d, loading_d, done_d;
  logic [ADDR_WIDTH-1:0]        addr_d;
  logic [DATA_WIDTH-1:0]        cmd_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_q      <= L_IDLE;
      rem_q           <= '0;
      idx_q           <= '0;
      op_q            <= '0;
      finish_q        <= 1'b0;
      program_write   <= 1'b0;
      program_address <= '0;
      program_cmd     <= '0;
      loading         <= 1'b0;
      load_done       <= 1'b0;
    end else begin
      ld_state_q      <= ld_state_d;
      rem_q           <= rem_d;
      idx_q           <= idx_d;
      op_q            <= op_d;
      finish_q        <= finish_d;
      program_write   <= write_d;
      program_address <= addr_d;
      program_cmd     <= cmd_d;
      loading         <= loading_d;
      load_done       <= done_d;
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    op_d       = op_q;
    finish_d   = 1'b0;
    write_d    = 1'b0;
    addr_d     = program_address;
    cmd_d      = program_cmd;
    loading_d  = loading;
    done_d     = 1'b0;
    // Session end is reported one cycle after the final write
    if (finish_q) begin
      done_d    = 1'b1;
      loading_d = 1'b0;
    end
    if (frame_error && ld_state_q != L_IDLE) begin
      ld_state_d = L_IDLE;
      loading_d  = 1'b0;
    end else if (byte_valid) begin
      case (ld_state_q)
        L_IDLE: begin
          if (rx_shift_q == SYNC_BYTE) begin
            ld_state_d = L_LEN;
            loading_d  = 1'b1;
            idx_d      = '0;
          end
        end
        L_LEN: begin
          rem_d      = (rx_shift_q == 8'd0) ? REM_W'(256) : REM_W'(rx_shift_q);
          ld_state_d = L_HI;
        end
        L_HI: begin
          op_d       = rx_shift_q[INSTRUCTION_WIDTH-1:0];
          ld_state_d = L_LO;
        end
        L_LO: begin
          write_d = 1'b1;
          addr_d  = idx_q;
          cmd_d   = DATA_WIDTH'({op_q, rx_shift_q[ADDR_WIDTH-1:0]});
          idx_d   = idx_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            ld_state_d = L_IDLE;
            finish_d   = 1'b1;
          end else begin
            ld_state_d = L_HI;
          end
        end
        default: ld_state_d = L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: table of load sessions plus
// hand-written glitch, full-depth and reset-mid-session sequences.
`timescale 1ns/1ps
module tb_uart_program_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        program_write;
  logic [7:0]  program_address;
  logic [11:0] program_cmd;
  logic        loading;
  logic        load_done;
  logic        frame_error;

  uart_program_loader #(
    .ADDR_WIDTH(8), .INSTRUCTION_WIDTH(4), .DATA_WIDTH(12),
    .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .program_write(program_write), .program_address(program_address),
    .program_cmd(program_cmd), .loading(loading),
    .load_done(load_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observed activity, sampled on the falling edge
  int wr_q[$];
  int last_wr_cyc, done_cyc, done_n, fe_n, both_n;
  logic load_at_wr, load_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (program_write) begin
      wr_q.push_back((int'(program_address) << 12) | int'(program_cmd));
      last_wr_cyc = cyc;
      load_at_wr  = loading;
    end
    if (load_done) begin
      done_n++;
      done_cyc     = cyc;
      load_at_done = loading;
    end
    if (frame_error) fe_n++;
    if (load_done && frame_error) both_n++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    wr_q.delete();
    done_n = 0; fe_n = 0; both_n = 0;
    last_wr_cyc = 0; done_cyc = 0;
    load_at_wr = 1'b0; load_at_done = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    rx = 1'b1;
    idle(2);
  endtask

  typedef struct {
    int               nbytes;
    logic [7:0][7:0]  bytes;
    logic             bad_last;
    logic             glitch;
    int               exp_writes;
    logic [1:0][11:0] exp_cmd;
    int               exp_done;
    int               exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // basic load
    vecs[0] = '{6, {8'h00,8'h00,8'hFF,8'h0C,8'h12,8'h03,8'h02,8'hA5}, 1'b0, 1'b0, 2, {12'hCFF,12'h312}, 1, 0};
    // junk before sync, upper nibble of hi byte ignored
    vecs[1] = '{6, {8'h00,8'h00,8'h05,8'h1A,8'h01,8'hA5,8'h5A,8'h00}, 1'b0, 1'b0, 1, {12'h000,12'hA05}, 1, 0};
    // frame error on the second word's hi byte
    vecs[2] = '{5, {8'h00,8'h00,8'h00,8'h55,8'h02,8'h01,8'h03,8'hA5}, 1'b1, 1'b0, 1, {12'h000,12'h102}, 0, 1};
    // recovery session after the abort
    vecs[3] = '{4, {8'h00,8'h00,8'h00,8'h00,8'h07,8'h00,8'h01,8'hA5}, 1'b0, 1'b0, 1, {12'h000,12'h007}, 1, 0};
    // glitch first, then sync byte used as data
    vecs[4] = '{4, {8'h00,8'h00,8'h00,8'h00,8'hA5,8'hA5,8'h01,8'hA5}, 1'b0, 1'b1, 1, {12'h000,12'h5A5}, 1, 0};

    rx    = 1'b1;
    reset = 1'b0;
    clear_obs();
    idle(3);
    chk("reset_write",   int'(program_write), 0);
    chk("reset_addr",    int'(program_address), 0);
    chk("reset_cmd",     int'(program_cmd), 0);
    chk("reset_loading", int'(loading), 0);
    chk("reset_done",    int'(load_done), 0);
    chk("reset_ferr",    int'(frame_error), 0);
    reset = 1'b1;
    idle(10);

    for (int v = 0; v < 5; v++) begin
      clear_obs();
      if (vecs[v].glitch) begin
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(4 * CPB);
        chk($sformatf("v%0d_glitch_ferr", v), fe_n, 0);
        chk($sformatf("v%0d_glitch_loading", v), int'(loading), 0);
      end
      for (int i = 0; i < vecs[v].nbytes; i++)
        send_byte(vecs[v].bytes[i], !(vecs[v].bad_last && i == vecs[v].nbytes - 1));
      idle(30);
      chk($sformatf("v%0d_writes", v), wr_q.size(), vecs[v].exp_writes);
      for (int k = 0; k < vecs[v].exp_writes; k++)
        chk($sformatf("v%0d_word%0d", v, k),
            (k < wr_q.size()) ? wr_q[k] : -1,
            (k << 12) | int'(vecs[v].exp_cmd[k]));
      chk($sformatf("v%0d_done", v), done_n, vecs[v].exp_done);
      chk($sformatf("v%0d_ferr", v), fe_n, vecs[v].exp_fe);
      chk($sformatf("v%0d_both", v), both_n, 0);
      chk($sformatf("v%0d_loading_end", v), int'(loading), 0);
      if (vecs[v].exp_done == 1) begin
        chk($sformatf("v%0d_done_lat", v), done_cyc - last_wr_cyc, 1);
        chk($sformatf("v%0d_loading_at_wr", v), int'(load_at_wr), 1);
        chk($sformatf("v%0d_loading_at_done", v), int'(load_at_done), 0);
      end
    end

    // Full depth: length 0 means 256 words, addresses 0..255 once each
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k >> 4), 1'b1);
      send_byte(8'(k), 1'b1);
    end
    idle(30);
    chk("full_writes", wr_q.size(), 256);
    for (int k = 0; k < 256; k++)
      chk($sformatf("full_word%0d", k),
          (k < wr_q.size()) ? wr_q[k] : -1,
          (k << 12) | (((k >> 4) & 15) << 8) | k);
    chk("full_done", done_n, 1);
    chk("full_done_lat", done_cyc - last_wr_cyc, 1);
    chk("full_loading_end", int'(loading), 0);

    // Reset in the middle of the third word
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    chk("rst_pre_writes", wr_q.size(), 2);
    chk("rst_pre_loading", int'(loading), 1);
    rx = 1'b0;
    idle(2 * CPB);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_write",   int'(program_write), 0);
    chk("rst_async_addr",    int'(program_address), 0);
    chk("rst_async_cmd",     int'(program_cmd), 0);
    chk("rst_async_loading", int'(loading), 0);
    chk("rst_async_done",    int'(load_done), 0);
    chk("rst_async_ferr",    int'(frame_error), 0);
    idle(5);
    reset = 1'b1;
    idle(3 * CPB);
    rx = 1'b1;
    idle(2 * CPB);
    clear_obs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(30);
    chk("rst_post_writes", wr_q.size(), 1);
    chk("rst_post_word", (wr_q.size() > 0) ? wr_q[0] : -1, 12'h033);
    chk("rst_post_done", done_n, 1);
    chk("rst_post_ferr", fe_n, 0);
    chk("rst_post_loading", int'(loading), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

- Upstream feeder of the program text RAM.
- Receives a serial 8N1 UART stream and decodes a framed load session. Each received byte pair is assembled into one instruction word (opcode + address field).
- Each word is written into consecutive program-memory locations through `program_write`/`program_address`/`program_cmd`.
- Asserts `loading` for the whole session so the top level can hold the processor, and pulses `load_done` when the final word has been written.

## Interface

Parameters:
- `ADDR_WIDTH`, 8: program-memory address width and operand field width; must be ≤ 8.
- `INSTRUCTION_WIDTH`, 4: opcode field width; must be ≤ 8.
- `DATA_WIDTH`, `ADDR_WIDTH + INSTRUCTION_WIDTH`: width of one program word.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 4 and even.
- `SYNC_BYTE`, 8'hA5: session start marker.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx` input 1: UART serial line; idles high; asynchronous to `clk`.
- `program_write` output 1: one-cycle write strobe to program memory.
- `program_address` output ADDR_WIDTH: write address, valid while `program_write` is high.
- `program_cmd` output DATA_WIDTH: word to write, valid while `program_write` is high.
- `loading` output 1: high while a session is in progress.
- `load_done` output 1: one-cycle pulse when a session completes.
- `frame_error` output 1: one-cycle pulse on a bad stop bit.

## Operation

Reset state:
- All outputs are 0.
- The `rx` synchronizer flops reset to 1.
- The receiver is in `RX_IDLE` and the loader is in `L_IDLE`.

Receiver:
- `rx` passes through a 2-flop synchronizer.
- `RX_IDLE`: a synchronized low moves to `RX_START`.
- `RX_START`: wait `CLKS_PER_BIT/2` cycles, then resample.
  - Low: go to `RX_DATA`.
  - High: false start; return to `RX_IDLE`. No output.
- `RX_DATA`: sample 8 bits LSB-first, one every `CLKS_PER_BIT` cycles, then go to `RX_STOP`.
- `RX_STOP`: sample one `CLKS_PER_BIT` later.
  - Sample = 1: internal `byte_valid` pulses for one cycle with the byte.
  - Sample = 0: `frame_error` pulses for one cycle and the byte is discarded.
- In both cases the receiver returns to `RX_IDLE`.

Loader FSM (advances only on `byte_valid` or `frame_error`):
- `L_IDLE`:
  - A byte equal to `SYNC_BYTE` goes to `L_LEN`, sets `loading` = 1 and clears the word index to 0.
  - Other bytes are ignored.
- `L_LEN`: the byte becomes the remaining count N; value 0 means 256. Go to `L_HI`.
- `L_HI`: store `byte[INSTRUCTION_WIDTH-1:0]` as the opcode; upper bits are ignored. Go to `L_LO`.
- `L_LO`, in the cycle after `byte_valid`:
  - `program_write` = 1.
  - `program_cmd` = {opcode, `byte[ADDR_WIDTH-1:0]`}.
  - `program_address` = word index.
  - Then the index increments (mod 2^ADDR_WIDTH) and N decrements.
  - N was not 1: go to `L_HI`.
  - N was 1: go to `L_IDLE`; `load_done` pulses the cycle after the final `program_write`, and `loading` falls in that same cycle.
- Inside a session `SYNC_BYTE` is ordinary data; there is no escaping.
- A `frame_error` in any state other than `L_IDLE`:
  - Aborts to `L_IDLE`; `loading` drops the next cycle and there is no `load_done`.
  - Words already written are not rolled back.
  - A pending half word (`L_LO`) is discarded.
- Index wrap: with `ADDR_WIDTH` = 8 and N = 256, addresses 0..255 are each written once. N greater than the memory depth wraps and overwrites from address 0.

## Timing

- Byte latency: stop-bit sample ≈ 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the falling edge of `rx` at the pins. `byte_valid`/`frame_error` fire in the cycle after that sample.
- `program_write` is exactly one cycle, one cycle after the `L_LO` `byte_valid`. Address and data are registered and stable in that cycle.
- Minimum spacing between `program_write` pulses is 20·`CLKS_PER_BIT` cycles. Memory needs no back-pressure.
- Reset asserted mid-byte or mid-session:
  - All outputs clear immediately (asynchronous).
  - The partial session is abandoned.
  - After release, the receiver waits for the line to go idle and then a fresh falling edge.
- `load_done` and `frame_error` are never high in the same cycle.

## Test plan

All scenarios use `CLKS_PER_BIT` = 16.

- **Basic load:** A5, 02, 0x03, 0x12, 0x0C, 0xFF → two writes:
  - addr 0, cmd 0x312.
  - addr 1, cmd 0xCFF.
  - `load_done` once, one cycle after the second write; `loading` then low.
- **Junk before sync:** 0x00, 0x5A, A5, 01, 0x1A, 0x05 → no writes before sync; one write, addr 0, cmd 0xA05 (upper nibble of 0x1A ignored).
- **Frame error mid-session:** A5, 03, then word 0x0102, then a byte with stop bit = 0 →
  - one write, addr 0, cmd 0x102.
  - `frame_error` one cycle, `loading` low, no `load_done`.
  - A following A5, 01, 0x00, 0x07 writes addr 0, cmd 0x007.
- **Glitch and sync-as-data:**
  - A 3-cycle low glitch on `rx` → no byte, no `frame_error`.
  - A5, 01, 0xA5, 0xA5 → one write, addr 0, cmd 0x5A5.
- **Full depth:** length byte 0x00 then 256 words → addresses 0..255 each written once, in order; `load_done` after address 255.
- **Reset mid-session:** reset pulled low during the third word → all outputs 0 immediately; after release, a new A5, 01 session writes addr 0.
